// File: rtl/mon_prod_radix.sv
// Montgomery product engine: P = A*B*2^-NBITS mod M, consuming RADIX_LOG bits of B per cycle.
// Operands are read word-serially from a 1-cycle-latency memory; the result is written back word-serially.
module mon_prod_radix #(
  parameter int NBITS     = 256,
  parameter int DBITS     = 64,
  parameter int ABITS     = 8,
  parameter int RADIX_LOG = 2,
  parameter int X_BASE    = 0,
  parameter int M_BASE    = 8,
  parameter int R_BASE    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op_code,
  input  logic [NBITS-1:0]     modulus,
  input  logic [RADIX_LOG-1:0] mu,
  output logic [ABITS-1:0]     rd_addr,
  input  logic [DBITS-1:0]     rd_data,
  output logic [ABITS-1:0]     wr_addr,
  output logic [DBITS-1:0]     wr_data,
  output logic                 wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [NBITS-1:0]     result,
  output logic [2:0]           dbg_state
);

  localparam int K  = RADIX_LOG;
  localparam int W  = NBITS / DBITS;
  localparam int I  = NBITS / K;
  localparam int CW = $clog2(W + I + 2);
  localparam int PW = NBITS + 2;
  localparam int SW = NBITS + K + 2;

  // Handshake: start is sampled only in S_IDLE; busy covers the load/compute/store
  // states, and done is a single-cycle pulse (with err for an illegal op_code).
  typedef enum logic [2:0] {
    S_IDLE, S_LOADA, S_LOADB, S_CALC, S_FINAL, S_STORE, S_DONE, S_ERR
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  logic [NBITS-1:0] a_q, b_q;
  logic [PW-1:0]   p_q;

  logic [K-1:0]    b_dig, t_dig, q_dig;
  logic [SW-1:0]   sum;
  logic [PW-1:0]   p_calc, p_fin;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (op_code == 2'd3) ? S_ERR : S_LOADA;
      S_LOADA: if (cnt == CW'(W)) state_nx = (op_q == 2'd1) ? S_LOADB : S_CALC;
      S_LOADB: if (cnt == CW'(W)) state_nx = S_CALC;
      S_CALC:  if (cnt == CW'(I - 1)) state_nx = S_FINAL;
      S_FINAL: state_nx = S_STORE;
      S_STORE: if (cnt == CW'(W - 1)) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state || state == S_IDLE) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);
    end
  end

  // One radix-2^K step; the sum keeps every carry so nothing is lost before the shift.
  always_comb begin
    b_dig  = b_q[K-1:0];
    t_dig  = p_q[K-1:0] + a_q[K-1:0] * b_dig;
    q_dig  = t_dig * mu;
    sum    = SW'(p_q) + SW'(b_dig) * SW'(a_q) + SW'(q_dig) * SW'(modulus);
    p_calc = PW'(sum >> K);
    p_fin  = (p_q >= PW'(modulus)) ? (p_q - PW'(modulus)) : p_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      result  <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          op_q <= op_code;
          p_q  <= '0;
          b_q  <= (op_code == 2'd2) ? NBITS'(1) : '0;
          if (op_code != 2'd3) rd_addr <= ABITS'(X_BASE);
        end
        S_LOADA: begin
          // rd_data lags rd_addr by one cycle, so word cnt-1 arrives now
          if (cnt != '0) begin
            a_q[DBITS*(int'(cnt)-1) +: DBITS] <= rd_data;
            if (op_q == 2'd0) b_q[DBITS*(int'(cnt)-1) +: DBITS] <= rd_data;
          end
          if (int'(cnt) + 1 < W)                  rd_addr <= ABITS'(X_BASE + int'(cnt) + 1);
          else if (cnt == CW'(W) && op_q == 2'd1) rd_addr <= ABITS'(M_BASE);
        end
        S_LOADB: begin
          if (cnt != '0) b_q[DBITS*(int'(cnt)-1) +: DBITS] <= rd_data;
          if (int'(cnt) + 1 < W) rd_addr <= ABITS'(M_BASE + int'(cnt) + 1);
        end
        S_CALC: begin
          p_q <= p_calc;
          b_q <= b_q >> K;
        end
        S_FINAL: begin
          p_q     <= p_fin;
          result  <= p_fin[NBITS-1:0];
          wr_addr <= ABITS'(R_BASE);
          wr_data <= p_fin[DBITS-1:0];
        end
        S_STORE: if (int'(cnt) + 1 < W) begin
          wr_addr <= ABITS'(R_BASE + int'(cnt) + 1);
          wr_data <= result[DBITS*(int'(cnt)+1) +: DBITS];
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state == S_LOADA) || (state == S_LOADB) || (state == S_CALC) ||
                     (state == S_FINAL) || (state == S_STORE);
  assign done      = (state == S_DONE) || (state == S_ERR);
  assign err       = (state == S_ERR);
  assign wr_en     = (state == S_STORE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mon_prod_radix.sv
// Bench for mon_prod_radix: small 8-bit vector table plus control corners, then a
// 256-bit radix-16 random run checked against a full-width REDC reference.
module tb_mon_prod_radix;

  localparam int XB = 0;
  localparam int MB = 8;
  localparam int RB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // ---------------- small instance: NBITS=DBITS=8, K=2 ----------------
  logic       start_s;
  logic [1:0] op_s;
  logic [7:0] mod_s;
  logic [1:0] mu_s;
  logic [7:0] rd_addr_s, rd_data_s, wr_addr_s, wr_data_s, result_s;
  logic       wr_en_s, busy_s, done_s, err_s;
  logic [2:0] dbg_s;
  logic [7:0] mem_s [0:255];

  mon_prod_radix #(.NBITS(8), .DBITS(8), .ABITS(8), .RADIX_LOG(2),
                   .X_BASE(XB), .M_BASE(MB), .R_BASE(RB)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .op_code(op_s), .modulus(mod_s), .mu(mu_s),
    .rd_addr(rd_addr_s), .rd_data(rd_data_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
    .wr_en(wr_en_s), .busy(busy_s), .done(done_s), .err(err_s), .result(result_s),
    .dbg_state(dbg_s));

  always @(posedge clk) rd_data_s <= mem_s[rd_addr_s];

  // ---------------- big instance: NBITS=256, DBITS=64, K=4 ----------------
  logic         start_b;
  logic [1:0]   op_b;
  logic [255:0] mod_b, result_b;
  logic [3:0]   mu_b;
  logic [7:0]   rd_addr_b, wr_addr_b;
  logic [63:0]  rd_data_b, wr_data_b;
  logic         wr_en_b, busy_b, done_b, err_b;
  logic [2:0]   dbg_b;
  logic [63:0]  mem_b [0:255];

  mon_prod_radix #(.NBITS(256), .DBITS(64), .ABITS(8), .RADIX_LOG(4),
                   .X_BASE(XB), .M_BASE(MB), .R_BASE(RB)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .op_code(op_b), .modulus(mod_b), .mu(mu_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
    .wr_en(wr_en_b), .busy(busy_b), .done(done_b), .err(err_b), .result(result_b),
    .dbg_state(dbg_b));

  always @(posedge clk) rd_data_b <= mem_b[rd_addr_b];

  // ---------------- reference model ----------------
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // -M^-1 mod 2^256 by Newton iteration (precision doubles each step)
  function automatic logic [255:0] neg_inv(input logic [255:0] m);
    logic [255:0] inv;
    inv = m;
    for (int i = 0; i < 8; i++) inv = inv * (256'd2 - m * inv);
    return ~inv + 256'd1;
  endfunction

  function automatic logic [255:0] redc(input logic [255:0] a, input logic [255:0] b,
                                        input logic [255:0] m, input logic [255:0] neg);
    logic [511:0] t;
    logic [255:0] q;
    logic [513:0] s;
    logic [257:0] p;
    t = {256'b0, a} * {256'b0, b};
    q = t[255:0] * neg;
    s = {2'b0, t} + {2'b0, {256'b0, q} * {256'b0, m}};
    p = s[513:256];
    if (p >= {2'b0, m}) p = p - {2'b0, m};
    return p[255:0];
  endfunction

  // ---------------- small-instance driver ----------------
  task automatic run_s(input logic [1:0] op, input logic [7:0] x, input logic [7:0] mb,
                       input int hold, output int lat, output int nwr,
                       output logic [7:0] wa, output logic [7:0] wd, output int nrd,
                       output logic [7:0] rd0, output logic [7:0] rd1,
                       output int ndone, output logic ev);
    logic [7:0] last_rd;
    lat = -1; nwr = 0; wa = '0; wd = '0; nrd = 0; rd0 = '0; rd1 = '0;
    ndone = 0; ev = 1'b0; last_rd = '0;
    mem_s[XB] = x;
    mem_s[MB] = mb;
    @(negedge clk);
    op_s = op;
    start_s = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == hold) start_s = 1'b0;
      if (wr_en_s) begin nwr++; wa = wr_addr_s; wd = wr_data_s; end
      if (busy_s && (nrd == 0 || rd_addr_s != last_rd)) begin
        if (nrd == 0) rd0 = rd_addr_s; else rd1 = rd_addr_s;
        nrd++;
        last_rd = rd_addr_s;
      end
      if (done_s) begin
        ndone++;
        if (lat < 0) begin lat = c; ev = err_s; end
      end
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] mb;
    logic [7:0] res;
    int         lat;
    int         nwr;
    int         nrd;
    logic       err;
  } vec_t;

  vec_t tbl [5];

  logic [255:0] exp_q [$];
  int           lat_q [$];
  int           t0_q  [$];

  initial begin
    int lat, nwr, nrd, nd;
    logic [7:0] wa, wd, rd0, rd1;
    logic ev;
    logic [255:0] m, x, mb, bv, neg, e, cap;
    logic [1:0] op;
    int wcnt, t0, el;
    bit seen;

    // op, x, M_bar, result, latency, writes, distinct read addrs, err
    tbl[0] = '{2'd2, 8'd5,  8'd0, 8'd2,  9,  1, 1, 1'b0};
    tbl[1] = '{2'd0, 8'd5,  8'd0, 8'd10, 9,  1, 1, 1'b0};
    tbl[2] = '{2'd1, 8'd5,  8'd7, 8'd1,  11, 1, 2, 1'b0};
    tbl[3] = '{2'd0, 8'd12, 8'd0, 8'd3,  9,  1, 1, 1'b0};
    tbl[4] = '{2'd3, 8'd9,  8'd0, 8'd3,  1,  0, 0, 1'b1};

    for (int i = 0; i < 256; i++) begin mem_s[i] = '0; mem_b[i] = '0; end

    // clock/reset
    rst_n = 1'b0;
    start_s = 1'b0; op_s = '0; mod_s = 8'd13; mu_s = 2'd3;
    start_b = 1'b0; op_b = '0; mod_b = 256'd1; mu_b = '0;
    repeat (2) @(negedge clk);
    check("rst_state",   dbg_s, 0);
    check("rst_busy",    busy_s, 0);
    check("rst_done",    done_s, 0);
    check("rst_err",     err_s, 0);
    check("rst_wr_en",   wr_en_s, 0);
    check("rst_rd_addr", rd_addr_s, 0);
    check("rst_wr_addr", wr_addr_s, 0);
    check("rst_wr_data", wr_data_s, 0);
    check("rst_result",  result_s, 0);
    check("rst_big_result", result_b, 0);
    check("rst_big_busy",   busy_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // table-driven small vectors
    for (int i = 0; i < 5; i++) begin
      run_s(tbl[i].op, tbl[i].x, tbl[i].mb, 1, lat, nwr, wa, wd, nrd, rd0, rd1, nd, ev);
      check($sformatf("v%0d_result", i),  result_s, tbl[i].res);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_ndone", i),   nd, 1);
      check($sformatf("v%0d_err", i),     ev, tbl[i].err);
      check($sformatf("v%0d_nwr", i),     nwr, tbl[i].nwr);
      check($sformatf("v%0d_wr_addr", i), wa, (tbl[i].nwr == 1) ? 8'(RB) : 8'd0);
      check($sformatf("v%0d_wr_data", i), wd, (tbl[i].nwr == 1) ? tbl[i].res : 8'd0);
      check($sformatf("v%0d_nrd", i),     nrd, tbl[i].nrd);
      check($sformatf("v%0d_rd0", i),     rd0, 8'(XB));
      check($sformatf("v%0d_rd1", i),     rd1, (tbl[i].nrd == 2) ? 8'(MB) : 8'd0);
    end

    // start held through LOADA/CALC must yield exactly one completion
    run_s(2'd0, 8'd5, 8'd0, 5, lat, nwr, wa, wd, nrd, rd0, rd1, nd, ev);
    check("held_ndone",   nd, 1);
    check("held_latency", lat, 9);
    check("held_result",  result_s, 10);
    check("held_nwr",     nwr, 1);

    // asynchronous reset in the middle of CALC
    mem_s[XB] = 8'd5;
    @(negedge clk);
    op_s = 2'd0;
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_state_calc", dbg_s, 3);
    check("mid_busy",       busy_s, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",  busy_s, 0);
    check("mid_rst_done",  done_s, 0);
    check("mid_rst_state", dbg_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nwr = 0; nd = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wr_en_s) nwr++;
      if (done_s) nd++;
    end
    check("mid_rst_nwr",    nwr, 0);
    check("mid_rst_ndone",  nd, 0);
    check("mid_rst_result", result_s, 0);

    // 256-bit random run with scoreboard
    for (int n = 0; n < 200; n++) begin
      m   = rand256() | 256'd1;
      x   = rand256() % m;
      mb  = rand256() % m;
      op  = 2'($urandom_range(0, 2));
      neg = neg_inv(m);
      bv  = (op == 2'd0) ? x : (op == 2'd1) ? mb : 256'd1;
      for (int k = 0; k < 4; k++) begin
        mem_b[XB + k] = x[k*64 +: 64];
        mem_b[MB + k] = mb[k*64 +: 64];
      end
      @(negedge clk);
      mod_b = m;
      mu_b  = neg[3:0];
      op_b  = op;
      start_b = 1'b1;
      exp_q.push_back(redc(x, bv, m, neg));
      lat_q.push_back((op == 2'd1) ? 80 : 75);
      t0_q.push_back(cyc);
      cap = '0; wcnt = 0; seen = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
        @(negedge clk);
        start_b = 1'b0;
        if (wr_en_b) begin
          check("big_wr_addr", wr_addr_b, 256'(RB + wcnt));
          if (wcnt < 4) cap[wcnt*64 +: 64] = wr_data_b;
          wcnt++;
        end
        if (done_b) begin
          seen = 1'b1;
          e  = exp_q.pop_front();
          el = lat_q.pop_front();
          t0 = t0_q.pop_front();
          check($sformatf("big%0d_result", n),  result_b, e);
          check($sformatf("big%0d_written", n), cap, e);
          check($sformatf("big%0d_nwr", n),     wcnt, 4);
          check($sformatf("big%0d_latency", n), cyc - t0, el);
          check($sformatf("big%0d_err", n),     err_b, 0);
        end
      end
      if (!seen) begin
        check($sformatf("big%0d_timeout", n), 0, 1);
        break;
      end
    end
    check("big_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
